// File: rtl/dq_abc_transform_seq_if.sv
// Handshake and data bundle between a dq<->abc transform and its neighbours.
interface dq_abc_transform_seq_if #(
  parameter int N = 32
);
  logic                in_valid;
  logic                in_ready;
  logic                mode;
  logic signed [N-1:0] in0;
  logic signed [N-1:0] in1;
  logic signed [N-1:0] ctheta;
  logic signed [N-1:0] stheta;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] out0;
  logic signed [N-1:0] out1;
  logic signed [N-1:0] out2;
  logic                ovf;
  logic                clear_ovf;

  modport master (
    output in_valid, mode, in0, in1, ctheta, stheta, out_ready, clear_ovf,
    input  in_ready, out_valid, out0, out1, out2, ovf
  );

  modport slave (
    input  in_valid, mode, in0, in1, ctheta, stheta, out_ready, clear_ovf,
    output in_ready, out_valid, out0, out1, out2, ovf
  );
endinterface

// File: rtl/dq_abc_transform_seq.sv
// Sequential dq<->abc current transform: one shared Q-format multiplier, five products
// per transform, saturating adds and a sticky overflow flag.
module dq_abc_transform_seq #(
  parameter int N = 32,
  parameter int Q = 18
) (
  input logic                   clk,
  input logic                   rst_n,
  dq_abc_transform_seq_if.slave bus
);
  localparam int W = N + 2;
  localparam logic signed [N-1:0] K_S3H = N'($rtoi(0.8660254037844386 * (2.0 ** Q) + 0.5));
  localparam logic signed [N-1:0] K_IS3 = N'($rtoi(0.5773502691896258 * (2.0 ** Q) + 0.5));

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SUM, S_OUT} state_t;

  state_t              state_r, state_n;
  logic [2:0]          step_r, step_n;
  logic                in_ready_s, accept_s;
  logic                mode_r;
  logic signed [N-1:0] x0_r, x1_r, c_r, s_r;
  logic signed [N-1:0] p0_r, p1_r, p2_r, p3_r, p4_r;
  logic signed [N-1:0] out0_r, out1_r, out2_r;
  logic                out_valid_r, ovf_r;
  logic signed [N-1:0] mul_a_s, mul_b_s;
  logic signed [2*N-1:0] mul_a_w, mul_b_w, mul_full_s, mul_sh_s;
  logic signed [W-1:0] beta_inv_w, fsum_w, alpha_w, half_w, r0_w, r1_w, r2_w;
  logic signed [N-1:0] alpha_s;
  logic                pre_sat_s, sum_sat_s, set_ovf_s;

  function automatic logic fits_n(input logic signed [2*N-1:0] x);
    return (&x[2*N-1:N-1]) | ~(|x[2*N-1:N-1]);
  endfunction

  function automatic logic signed [N-1:0] sat_n(input logic signed [2*N-1:0] x);
    logic signed [N-1:0] r;
    if (fits_n(x)) begin
      r = x[N-1:0];
    end else if (x[2*N-1]) begin
      r = {1'b1, {(N-1){1'b0}}};
    end else begin
      r = {1'b0, {(N-1){1'b1}}};
    end
    return r;
  endfunction

  function automatic logic signed [2*N-1:0] ext_w(input logic signed [W-1:0] x);
    return {{(2*N-W){x[W-1]}}, x};
  endfunction

  function automatic logic signed [W-1:0] ext_n(input logic signed [N-1:0] x);
    return {{2{x[N-1]}}, x};
  endfunction

  // Next-state logic and input handshake
  always_comb begin
    state_n    = state_r;
    step_n     = step_r;
    in_ready_s = (state_r == S_IDLE) | ((state_r == S_OUT) & bus.out_ready);
    accept_s   = bus.in_valid & in_ready_s;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_n = S_MUL;
          step_n  = 3'd0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_MUL: begin
        if (step_r == 3'd4) begin
          state_n = S_SUM;
          step_n  = 3'd0;
        end else begin
          step_n = step_r + 3'd1;
        end
      end
      S_SUM: state_n = S_OUT;
      S_OUT: begin
        if (bus.out_ready) begin
          state_n = accept_s ? S_MUL : S_IDLE;
          step_n  = 3'd0;
        end else begin
          state_n = S_OUT;
        end
      end
      default: begin
        state_n = S_IDLE;
        step_n  = 3'd0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      step_r  <= 3'd0;
    end else begin
      state_r <= state_n;
      step_r  <= step_n;
    end
  end

  // Multiplier operand selection; the pre-multiply sums are saturated to N bits first
  always_comb begin
    beta_inv_w = ext_n(p2_r) + ext_n(p3_r);
    fsum_w     = ext_n(x0_r) + (ext_n(x1_r) <<< 1);
    mul_a_s    = {N{1'b0}};
    mul_b_s    = {N{1'b0}};
    pre_sat_s  = 1'b0;
    if (mode_r) begin
      case (step_r)
        3'd0: begin
          mul_a_s   = K_IS3;
          mul_b_s   = sat_n(ext_w(fsum_w));
          pre_sat_s = ~fits_n(ext_w(fsum_w));
        end
        3'd1: begin mul_a_s = c_r; mul_b_s = x0_r; end
        3'd2: begin mul_a_s = s_r; mul_b_s = p0_r; end
        3'd3: begin mul_a_s = s_r; mul_b_s = x0_r; end
        3'd4: begin mul_a_s = c_r; mul_b_s = p0_r; end
        default: begin mul_a_s = {N{1'b0}}; mul_b_s = {N{1'b0}}; end
      endcase
    end else begin
      case (step_r)
        3'd0: begin mul_a_s = c_r; mul_b_s = x0_r; end
        3'd1: begin mul_a_s = s_r; mul_b_s = x1_r; end
        3'd2: begin mul_a_s = s_r; mul_b_s = x0_r; end
        3'd3: begin mul_a_s = c_r; mul_b_s = x1_r; end
        3'd4: begin
          mul_a_s   = K_S3H;
          mul_b_s   = sat_n(ext_w(beta_inv_w));
          pre_sat_s = ~fits_n(ext_w(beta_inv_w));
        end
        default: begin mul_a_s = {N{1'b0}}; mul_b_s = {N{1'b0}}; end
      endcase
    end
  end

  assign mul_a_w    = $signed({{N{mul_a_s[N-1]}}, mul_a_s});
  assign mul_b_w    = $signed({{N{mul_b_s[N-1]}}, mul_b_s});
  assign mul_full_s = mul_a_w * mul_b_w;
  assign mul_sh_s   = mul_full_s >>> Q;

  // Final adds in N+2 bits; alpha is saturated before it feeds ib/ic
  always_comb begin
    alpha_w = ext_n(p0_r) - ext_n(p1_r);
    alpha_s = sat_n(ext_w(alpha_w));
    half_w  = ext_n(alpha_s >>> 1);
    if (mode_r) begin
      r0_w      = ext_n(p1_r) + ext_n(p2_r);
      r1_w      = ext_n(p4_r) - ext_n(p3_r);
      r2_w      = {W{1'b0}};
      sum_sat_s = ~fits_n(ext_w(r0_w)) | ~fits_n(ext_w(r1_w));
    end else begin
      r0_w      = ext_n(alpha_s);
      r1_w      = ext_n(p4_r) - half_w;
      r2_w      = -half_w - ext_n(p4_r);
      sum_sat_s = ~fits_n(ext_w(alpha_w)) | ~fits_n(ext_w(r1_w)) | ~fits_n(ext_w(r2_w));
    end
  end

  assign set_ovf_s = ((state_r == S_MUL) & (pre_sat_s | ~fits_n(mul_sh_s)))
                   | ((state_r == S_SUM) & sum_sat_s);

  // Operand capture on accept; changes while busy are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= 1'b0;
      x0_r   <= {N{1'b0}};
      x1_r   <= {N{1'b0}};
      c_r    <= {N{1'b0}};
      s_r    <= {N{1'b0}};
    end else if (accept_s) begin
      mode_r <= bus.mode;
      x0_r   <= bus.in0;
      x1_r   <= bus.in1;
      c_r    <= bus.ctheta;
      s_r    <= bus.stheta;
    end else begin
      mode_r <= mode_r;
    end
  end

  // Product registers, one per multiply step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_r <= {N{1'b0}};
      p1_r <= {N{1'b0}};
      p2_r <= {N{1'b0}};
      p3_r <= {N{1'b0}};
      p4_r <= {N{1'b0}};
    end else if (state_r == S_MUL) begin
      case (step_r)
        3'd0:    p0_r <= sat_n(mul_sh_s);
        3'd1:    p1_r <= sat_n(mul_sh_s);
        3'd2:    p2_r <= sat_n(mul_sh_s);
        3'd3:    p3_r <= sat_n(mul_sh_s);
        3'd4:    p4_r <= sat_n(mul_sh_s);
        default: p0_r <= p0_r;
      endcase
    end else begin
      p0_r <= p0_r;
    end
  end

  // Result registers and output valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_r      <= {N{1'b0}};
      out1_r      <= {N{1'b0}};
      out2_r      <= {N{1'b0}};
      out_valid_r <= 1'b0;
    end else if (state_r == S_SUM) begin
      out0_r      <= sat_n(ext_w(r0_w));
      out1_r      <= sat_n(ext_w(r1_w));
      out2_r      <= sat_n(ext_w(r2_w));
      out_valid_r <= 1'b1;
    end else if ((state_r == S_OUT) & bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Sticky overflow; clear wins over a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (bus.clear_ovf) begin
      ovf_r <= 1'b0;
    end else if (set_ovf_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out0      = out0_r;
  assign bus.out1      = out1_r;
  assign bus.out2      = out2_r;
  assign bus.ovf       = ovf_r;
endmodule
